// File: rtl/piso_frame_serializer.sv
// rtl/piso_frame_serializer.sv - PISO frame serializer: start bit, WIDTH data bits LSB first, optional even parity (PISO_FRAME_PARITY_EN), stop bit
module piso_frame_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_FRAME_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_en_q;
`ifdef PISO_FRAME_PARITY_EN
    logic               par_q;
`endif

    logic               accept;
    logic               last_bit;

    // load_ready is a decode of registered state, so accept has no input-to-output path
    assign accept   = load_valid & load_ready;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State register; reset forces IDLE without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: STOP can chain straight into START for gapless frames
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: state_d = S_DATA;
            S_DATA: begin
                if (last_bit) begin
`ifdef PISO_FRAME_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef PISO_FRAME_PARITY_EN
            S_PARITY: state_d = S_STOP;
`endif
            S_STOP:  state_d = accept ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state and registered datapath only
    always_comb begin
        so         = IDLE_LEVEL;
        busy       = 1'b1;
        done       = 1'b0;
        load_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy       = 1'b0;
                load_ready = ready_en_q;
            end
            S_START: so = ~IDLE_LEVEL;
            S_DATA:  so = shift_q[0];
`ifdef PISO_FRAME_PARITY_EN
            S_PARITY: so = par_q;
`endif
            S_STOP: begin
                done       = 1'b1;
                load_ready = ready_en_q;
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath: capture on accept, shift right during DATA, hold counter at the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
`ifdef PISO_FRAME_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            // ready is held off until the first edge after reset release
            ready_en_q <= 1'b1;
            if (accept) begin
                shift_q <= din;
                cnt_q   <= '0;
`ifdef PISO_FRAME_PARITY_EN
                par_q   <= ^din;
`endif
            end else if (state_q == S_DATA) begin
                shift_q <= shift_q >> 1;
                if (!last_bit) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule
